// File: rtl/stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_fifo: FWFT valid/ready FIFO, any DEPTH>=2, programmable AF/AE flags  |
// | Optional high-water mark enabled by defining STREAM_FIFO_HWM_EN.             |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic [CW-1:0]         af_thresh_i,
  input  logic [CW-1:0]         ae_thresh_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CW-1:0]         count_o,
  output logic [CW-1:0]         free_o,
  input  logic                  hwm_clr_i,
  output logic [CW-1:0]         hwm_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [CW-1:0]         w_count;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes are blocked during reset and flush, so neither side sees a transfer.
  assign s_ready_o = rst_n_i && !flush_i && (count_q != CW'(DEPTH));
  assign m_valid_o = rst_n_i && !flush_i && (count_q != '0);
  assign w_push    = s_valid_i && s_ready_o;
  assign w_pop     = m_valid_o && m_ready_i;
  assign m_data_o  = m_valid_o ? mem_q[rd_ptr_q] : '0;

  assign w_count        = rst_n_i ? count_q : '0;
  assign full_o         = (w_count == CW'(DEPTH));
  assign empty_o        = (w_count == '0);
  assign almost_full_o  = (w_count >= af_thresh_i);
  assign almost_empty_o = (w_count <= ae_thresh_i);
  assign count_o        = w_count;
  assign free_o         = CW'(DEPTH) - w_count;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_push && w_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= f_next(wr_ptr_q);
      if (w_pop)  rd_ptr_q <= f_next(rd_ptr_q);
      count_q <= count_d;
    end
  end

`ifdef STREAM_FIFO_HWM_EN
  logic [CW-1:0] hwm_q;

  // Flush yields count_d == 0, which never exceeds the mark, so hwm holds.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hwm_q <= '0;
    end else if (hwm_clr_i) begin
      hwm_q <= count_d;
    end else if (count_d > hwm_q) begin
      hwm_q <= count_d;
    end
  end

  assign hwm_o = rst_n_i ? hwm_q : '0;
`else
  logic w_unused_hwm_clr;

  assign w_unused_hwm_clr = hwm_clr_i;
  assign hwm_o            = '0;
`endif

endmodule
`default_nettype wire
